// File: rtl/hd63701_int_sequencer.sv
// HD63701 interrupt priority sequencer.
// Collects the external pins, the timer/SCI level requests and the illegal-opcode TRAP. At an
// opcode-fetch boundary it presents one request and the low byte of its vector ({8'hFF, VEC}).
// WAKE pulses for WAI/SLP when an eligible source appears while idle.
// Build option: define HD63701_INTSEQ_SYNC_EN to put 2-flop synchronisers on NMI_n/IRQ1_n/IRQ2_n;
// without it the pins are registered once.
module hd63701_int_sequencer #(
    parameter int unsigned NMI_EDGE    = 1,  // 1: NMI latched on falling edge, 0: level
    parameter int unsigned ACK_TIMEOUT = 0   // 0: never abandon a request
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       NMI_n,
    input  logic       IRQ1_n,
    input  logic       IRQ2_n,
    input  logic       SRC_ICF,
    input  logic       SRC_OCF,
    input  logic       SRC_TOF,
    input  logic       SRC_CMI,
    input  logic       SRC_SCI,
    input  logic       TRAP,
    input  logic       INTE,
    input  logic       BOUNDARY,
    input  logic       ACK,
    output logic       REQ,
    output logic [7:0] VEC,
    output logic       WAKE,
    output logic       TMO
);

    typedef enum logic [0:0] {StIdle, StReq} state_e;

    localparam logic [7:0] VecTrap = 8'hEE;
    localparam logic [7:0] VecNmi  = 8'hFC;

    // Pin order in the sync vectors: {NMI_n, IRQ1_n, IRQ2_n}
    logic [2:0] pin_sync_d, pin_sync_q;

`ifdef HD63701_INTSEQ_SYNC_EN
    logic [2:0] pin_meta_d, pin_meta_q;

    // Two-stage synchroniser, first stage
    always_comb begin
        pin_meta_d = {NMI_n, IRQ1_n, IRQ2_n};
        pin_sync_d = pin_meta_q;
    end

    // Synchroniser flops idle high (pins inactive)
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pin_meta_q <= 3'b111;
            pin_sync_q <= 3'b111;
        end else begin
            pin_meta_q <= pin_meta_d;
            pin_sync_q <= pin_sync_d;
        end
    end
`else
    // Single pin register
    always_comb begin
        pin_sync_d = {NMI_n, IRQ1_n, IRQ2_n};
    end

    // Pin register idles high (pins inactive)
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pin_sync_q <= 3'b111;
        end else begin
            pin_sync_q <= pin_sync_d;
        end
    end
`endif

    state_e      state_d, state_q;
    logic [7:0]  vec_d, vec_q;
    logic        trap_d, trap_q;
    logic        nmi_d, nmi_q;
    logic        nmi_prev_d, nmi_prev_q;
    logic        elig_prev_d, elig_prev_q;
    logic        wake_d, wake_q;
    logic        tmo_d, tmo_q;
    logic [15:0] timer_d, timer_q;

    logic        nmi_s, irq1, irq2, nmi_edge, nmi_pend;
    logic [6:0]  mask_src;
    logic        elig_any;
    logic [7:0]  vec_sel;
    logic        timeout_hit;

    // Eligibility and fixed-priority vector selection
    always_comb begin
        nmi_s    = pin_sync_q[2];
        irq1     = ~pin_sync_q[1];
        irq2     = ~pin_sync_q[0];
        nmi_edge = (NMI_EDGE != 0) && nmi_prev_q && !nmi_s;
        // The edge itself counts so edge mode sees the same pin latency as the level pins
        nmi_pend = (NMI_EDGE != 0) ? (nmi_q || nmi_edge) : !nmi_s;
        mask_src = {irq1, SRC_ICF, SRC_OCF, SRC_TOF, SRC_CMI, irq2, SRC_SCI} & {7{INTE}};
        elig_any = trap_q || nmi_pend || (|mask_src);
        if (trap_q)           vec_sel = VecTrap;
        else if (nmi_pend)    vec_sel = VecNmi;
        else if (mask_src[6]) vec_sel = 8'hF8;
        else if (mask_src[5]) vec_sel = 8'hF6;
        else if (mask_src[4]) vec_sel = 8'hF4;
        else if (mask_src[3]) vec_sel = 8'hF2;
        else if (mask_src[2]) vec_sel = 8'hEC;
        else if (mask_src[1]) vec_sel = 8'hEA;
        else                  vec_sel = 8'hF0;
        timeout_hit = (ACK_TIMEOUT != 0) && (timer_q == 16'(ACK_TIMEOUT - 1));
    end

    // Next-state: arbitration, latch maintenance, ack/timeout handling
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        trap_d      = trap_q || TRAP;
        nmi_d       = (NMI_EDGE != 0) && (nmi_q || nmi_edge);
        nmi_prev_d  = nmi_s;
        elig_prev_d = elig_any;
        wake_d      = (state_q == StIdle) && elig_any && !elig_prev_q;
        tmo_d       = 1'b0;
        timer_d     = timer_q;
        unique case (state_q)
            StIdle: begin
                if (BOUNDARY && elig_any) begin
                    state_d = StReq;
                    vec_d   = vec_sel;
                    timer_d = '0;
                end
            end
            StReq: begin
                if (ACK) begin
                    state_d = StIdle;
                    // A fresh TRAP pulse or NMI edge in the ack cycle keeps its latch set
                    if (vec_q == VecTrap) begin
                        trap_d = TRAP;
                    end else if (vec_q == VecNmi && NMI_EDGE != 0) begin
                        nmi_d = nmi_edge;
                    end
                end else if (timeout_hit) begin
                    state_d = StIdle;
                    tmo_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= StIdle;
            vec_q       <= 8'h00;
            trap_q      <= 1'b0;
            nmi_q       <= 1'b0;
            nmi_prev_q  <= 1'b1;
            elig_prev_q <= 1'b0;
            wake_q      <= 1'b0;
            tmo_q       <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            trap_q      <= trap_d;
            nmi_q       <= nmi_d;
            nmi_prev_q  <= nmi_prev_d;
            elig_prev_q <= elig_prev_d;
            wake_q      <= wake_d;
            tmo_q       <= tmo_d;
            timer_q     <= timer_d;
        end
    end

    assign REQ  = (state_q == StReq);
    assign VEC  = vec_q;
    assign WAKE = wake_q;
    assign TMO  = tmo_q;

endmodule

// File: tb/tb_hd63701_int_sequencer.sv
// Bench for hd63701_int_sequencer: vector table for arbitration plus hand-written sequences for
// NMI edge, preemption, TRAP/ACK collision, timeout, WAKE and asynchronous reset.
module tb_hd63701_int_sequencer;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic NMI_n = 1'b1, IRQ1_n = 1'b1, IRQ2_n = 1'b1;
    logic SRC_ICF = 1'b0, SRC_OCF = 1'b0, SRC_TOF = 1'b0, SRC_CMI = 1'b0, SRC_SCI = 1'b0;
    logic TRAP = 1'b0, INTE = 1'b0, BOUNDARY = 1'b0, ACK = 1'b0;
    logic       req0, wake0, tmo0, req1, wake1, tmo1;
    logic [7:0] vec0, vec1;

    always #5 CLK = ~CLK;

    hd63701_int_sequencer #(.NMI_EDGE(1), .ACK_TIMEOUT(0)) dut (
        .CLK(CLK), .RST(RST), .NMI_n(NMI_n), .IRQ1_n(IRQ1_n), .IRQ2_n(IRQ2_n),
        .SRC_ICF(SRC_ICF), .SRC_OCF(SRC_OCF), .SRC_TOF(SRC_TOF), .SRC_CMI(SRC_CMI),
        .SRC_SCI(SRC_SCI), .TRAP(TRAP), .INTE(INTE), .BOUNDARY(BOUNDARY), .ACK(ACK),
        .REQ(req0), .VEC(vec0), .WAKE(wake0), .TMO(tmo0)
    );

    hd63701_int_sequencer #(.NMI_EDGE(1), .ACK_TIMEOUT(4)) dut_t (
        .CLK(CLK), .RST(RST), .NMI_n(NMI_n), .IRQ1_n(IRQ1_n), .IRQ2_n(IRQ2_n),
        .SRC_ICF(SRC_ICF), .SRC_OCF(SRC_OCF), .SRC_TOF(SRC_TOF), .SRC_CMI(SRC_CMI),
        .SRC_SCI(SRC_SCI), .TRAP(TRAP), .INTE(INTE), .BOUNDARY(BOUNDARY), .ACK(ACK),
        .REQ(req1), .VEC(vec1), .WAKE(wake1), .TMO(tmo1)
    );

    // src order: {ICF, OCF, TOF, CMI, SCI}
    typedef struct packed {
        logic       inte;
        logic       irq1_n;
        logic       irq2_n;
        logic [4:0] src;
        logic       nmi_fall;
        logic       trap;
        logic       exp_req;
        logic [7:0] exp_vec;
    } vec_t;

    vec_t       tbl[12];
    logic [7:0] exp_q[$];
    int         n_cmp = 0;
    int         n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_boundary();
        BOUNDARY = 1'b1;
        tick();
        BOUNDARY = 1'b0;
    endtask

    task automatic pulse_ack();
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
    endtask

    task automatic clear_inputs();
        NMI_n = 1'b1; IRQ1_n = 1'b1; IRQ2_n = 1'b1;
        SRC_ICF = 1'b0; SRC_OCF = 1'b0; SRC_TOF = 1'b0; SRC_CMI = 1'b0; SRC_SCI = 1'b0;
        TRAP = 1'b0; INTE = 1'b0; BOUNDARY = 1'b0; ACK = 1'b0;
    endtask

    // Scoreboard: a rising REQ must match the oldest queued vector; no REQ if nothing queued
    task automatic sb_sample(input string name);
        @(negedge CLK);
        if (req0) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL %s: got REQ=1 VEC=%0h required REQ=0", name, vec0);
            end else begin
                check(name, {24'd0, vec0}, {24'd0, exp_q.pop_front()});
            end
        end else if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: got REQ=0 required REQ=1 VEC=%0h", name, exp_q.pop_front());
        end else begin
            check(name, {31'd0, req0}, 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int wakes;
        //             inte irq1 irq2 src       nmi  trap exp  vec
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 5'b01000, 1'b0, 1'b0, 1'b1, 8'hF4};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 5'b11111, 1'b0, 1'b0, 1'b1, 8'hF6};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 5'b00111, 1'b0, 1'b0, 1'b1, 8'hF2};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 5'b00011, 1'b0, 1'b0, 1'b1, 8'hEC};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 5'b00001, 1'b0, 1'b0, 1'b1, 8'hEA};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 5'b00001, 1'b0, 1'b0, 1'b1, 8'hF0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 5'b11111, 1'b0, 1'b0, 1'b1, 8'hF8};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 5'b11111, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 5'b00000, 1'b1, 1'b0, 1'b1, 8'hFC};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 5'b00001, 1'b0, 1'b1, 1'b1, 8'hEE};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 5'b00000, 1'b1, 1'b0, 1'b1, 8'hFC};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h00};

        // Reset state
        clear_inputs();
        repeat (2) tick();
        @(negedge CLK);
        check("rst_req", {31'd0, req0}, 32'd0);
        check("rst_vec", {24'd0, vec0}, 32'h00);
        check("rst_wake", {31'd0, wake0}, 32'd0);
        check("rst_tmo", {31'd0, tmo0}, 32'd0);
        check("rst_req_t", {31'd0, req1}, 32'd0);
        tick();
        RST = 1'b0;
        repeat (3) tick();

        // Table-driven arbitration
        for (int i = 0; i < 12; i++) begin
            clear_inputs();
            INTE = tbl[i].inte;
            IRQ1_n = tbl[i].irq1_n;
            IRQ2_n = tbl[i].irq2_n;
            {SRC_ICF, SRC_OCF, SRC_TOF, SRC_CMI, SRC_SCI} = tbl[i].src;
            if (tbl[i].nmi_fall) NMI_n = 1'b0;
            if (tbl[i].trap) begin
                TRAP = 1'b1;
                tick();
                TRAP = 1'b0;
            end
            repeat (3) tick();
            if (tbl[i].exp_req) exp_q.push_back(tbl[i].exp_vec);
            pulse_boundary();
            sb_sample($sformatf("tbl%0d_vec", i));
            if (tbl[i].exp_req) begin
                pulse_ack();
                @(negedge CLK);
                check($sformatf("tbl%0d_ack", i), {31'd0, req0}, 32'd0);
            end
            clear_inputs();
            repeat (3) tick();
        end

        // NMI held low is taken once only
        INTE = 1'b0; IRQ1_n = 1'b0; NMI_n = 1'b0;
        repeat (3) tick();
        exp_q.push_back(8'hFC);
        pulse_boundary();
        sb_sample("nmi_once_vec");
        pulse_ack();
        repeat (2) tick();
        pulse_boundary();
        sb_sample("nmi_held_noreq");
        clear_inputs();
        repeat (3) tick();

        // No preemption in REQ; boundary in REQ ignored; NMI taken afterwards
        INTE = 1'b1; SRC_TOF = 1'b1;
        repeat (2) tick();
        exp_q.push_back(8'hF2);
        pulse_boundary();
        sb_sample("preempt_first");
        NMI_n = 1'b0;
        repeat (3) tick();
        pulse_boundary();
        @(negedge CLK);
        check("preempt_vec_frozen", {24'd0, vec0}, 32'hF2);
        check("preempt_req_held", {31'd0, req0}, 32'd1);
        pulse_ack();
        @(negedge CLK);
        check("preempt_ack", {31'd0, req0}, 32'd0);
        exp_q.push_back(8'hFC);
        pulse_boundary();
        sb_sample("preempt_nmi");
        pulse_ack();
        exp_q.push_back(8'hF2);
        pulse_boundary();
        sb_sample("preempt_tof_again");
        SRC_TOF = 1'b0;
        pulse_ack();
        clear_inputs();
        repeat (3) tick();

        // TRAP with SCI pending, then SCI
        INTE = 1'b1; SRC_SCI = 1'b1; TRAP = 1'b1;
        tick();
        TRAP = 1'b0;
        repeat (2) tick();
        exp_q.push_back(8'hEE);
        pulse_boundary();
        sb_sample("trap_sci_trap");
        pulse_ack();
        exp_q.push_back(8'hF0);
        pulse_boundary();
        sb_sample("trap_sci_sci");
        SRC_SCI = 1'b0;
        pulse_ack();
        clear_inputs();
        repeat (3) tick();

        // New TRAP in the ack cycle of a TRAP request stays latched
        TRAP = 1'b1;
        tick();
        TRAP = 1'b0;
        exp_q.push_back(8'hEE);
        pulse_boundary();
        sb_sample("trap_ack_first");
        ACK = 1'b1; TRAP = 1'b1;
        tick();
        ACK = 1'b0; TRAP = 1'b0;
        exp_q.push_back(8'hEE);
        pulse_boundary();
        sb_sample("trap_ack_retained");
        pulse_ack();
        clear_inputs();
        repeat (3) tick();

        // ACK timeout on the ACK_TIMEOUT=4 instance
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tick();
        INTE = 1'b1; SRC_OCF = 1'b1;
        repeat (3) tick();
        pulse_boundary();
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (!req1) break;
            cnt++;
        end
        check("tmo_req_cycles", cnt, 32'd4);
        check("tmo_pulse", {31'd0, tmo1}, 32'd1);
        check("tmo_none_no_timeout", {31'd0, req0}, 32'd1);
        @(negedge CLK);
        check("tmo_pulse_end", {31'd0, tmo1}, 32'd0);
        pulse_boundary();
        @(negedge CLK);
        check("tmo_rearb_req", {31'd0, req1}, 32'd1);
        check("tmo_rearb_vec", {24'd0, vec1}, 32'hF4);
        SRC_OCF = 1'b0;
        pulse_ack();
        clear_inputs();
        repeat (3) tick();

        // WAKE without BOUNDARY, then asynchronous reset mid-REQ
        RST = 1'b1;
        tick();
        RST = 1'b0;
        repeat (3) tick();
        INTE = 1'b1; IRQ2_n = 1'b0;
        wakes = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            if (wake0) wakes++;
        end
        check("wake_count", wakes, 32'd1);
        check("wake_no_req", {31'd0, req0}, 32'd0);
        exp_q.push_back(8'hEA);
        pulse_boundary();
        sb_sample("wake_irq2_vec");
        RST = 1'b1;
        #1;
        check("async_rst_req", {31'd0, req0}, 32'd0);
        check("async_rst_vec", {24'd0, vec0}, 32'h00);
        tick();
        RST = 1'b0;
        clear_inputs();
        repeat (2) tick();

        check("sb_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
